// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_pkg
//  Brief    : Shared AXI4-Lite response codes and channel FSM state types,
//             common to the slave register file and the matching master.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Byte-address bits below the 32-bit word index
   localparam int WORD_LSB = 2;

   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_e;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_regfile
//  Brief    : NUM_REGS x DATA_W register storage with a byte-strobed write
//             port, combinational read port, range flags and flat export.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         wr_en,
   input  logic [ADDR_W-WORD_LSB-1:0]   wr_idx,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic [DATA_W/8-1:0]          wr_strb,
   output logic                         wr_in_range,
   input  logic [ADDR_W-WORD_LSB-1:0]   rd_idx,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_in_range,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out
);

   localparam int IDX_W = ADDR_W - WORD_LSB;
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [SEL_W-1:0]  wr_sel;
   logic [SEL_W-1:0]  rd_sel;

   // Full-width compare so aliased high address bits never hit a register
   assign wr_in_range = (wr_idx < IDX_W'(NUM_REGS));
   assign rd_in_range = (rd_idx < IDX_W'(NUM_REGS));
   assign wr_sel      = wr_idx[SEL_W-1:0];
   assign rd_sel      = rd_idx[SEL_W-1:0];

   // Out-of-range reads return zero rather than an aliased register
   assign rd_data = rd_in_range ? regs_q[rd_sel] : '0;

   // Next register contents: merge only the strobed bytes of an in-range write
   always_comb begin
      regs_d = regs_q;
      if (wr_en && wr_in_range) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_strb[b]) begin
               regs_d[wr_sel][b*8 +: 8] = wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Register storage, cleared by reset
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
         assign regs_out[i*DATA_W +: DATA_W] = regs_q[i];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_slave_regfile
//  Brief    : AXI4-Lite slave over a bank of 32-bit registers. Independent
//             write (AW/W/B) and read (AR/R) FSMs, all outputs registered.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regfile
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [ADDR_W-1:0]          awaddr,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/8-1:0]        wstrb,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [1:0]                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   input  logic [ADDR_W-1:0]          araddr,
   input  logic                       arvalid,
   output logic                       arready,
   output logic [DATA_W-1:0]          rdata,
   output logic [1:0]                 rresp,
   output logic                       rvalid,
   input  logic                       rready,
   output logic [NUM_REGS*DATA_W-1:0] regs_out
);

   localparam int IDX_W = ADDR_W - WORD_LSB;

   // Write channel state
   wr_state_e              wr_state_q, wr_state_d;
   logic                   aw_held_q, aw_held_d;
   logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
   logic                   w_held_q, w_held_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [DATA_W/8-1:0]    wstrb_q, wstrb_d;
   logic                   awready_q, awready_d;
   logic                   wready_q, wready_d;
   logic                   bvalid_q, bvalid_d;
   logic [1:0]             bresp_q, bresp_d;
   logic                   wr_commit;

   // Read channel state
   rd_state_e              rd_state_q, rd_state_d;
   logic                   arready_q, arready_d;
   logic                   rvalid_q, rvalid_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [1:0]             rresp_q, rresp_d;

   // Register file ports
   logic                   rf_wr_in_range;
   logic [DATA_W-1:0]      rf_rd_data;
   logic                   rf_rd_in_range;

   // Byte-offset bits do not select anything
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{awaddr[WORD_LSB-1:0], araddr[WORD_LSB-1:0]};

   axi_lite_regfile #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .aclk        (aclk),
      .areset      (areset),
      .wr_en       (wr_commit),
      .wr_idx      (aw_idx_q),
      .wr_data     (wdata_q),
      .wr_strb     (wstrb_q),
      .wr_in_range (rf_wr_in_range),
      .rd_idx      (araddr[ADDR_W-1:WORD_LSB]),
      .rd_data     (rf_rd_data),
      .rd_in_range (rf_rd_in_range),
      .regs_out    (regs_out)
   );

   // Write FSM next state: collect AW and W in any order, commit once both held
   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_commit  = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (awvalid && awready_q) begin
               aw_held_d = 1'b1;
               aw_idx_d  = awaddr[ADDR_W-1:WORD_LSB];
            end
            if (wvalid && wready_q) begin
               w_held_d = 1'b1;
               wdata_d  = wdata;
               wstrb_d  = wstrb;
            end
            // Readies are low while both are held, so no new payload collides
            if (aw_held_q && w_held_q) begin
               wr_commit  = 1'b1;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               bvalid_d   = 1'b1;
               bresp_d    = rf_wr_in_range ? RESP_OKAY : RESP_SLVERR;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bready) begin
               bvalid_d   = 1'b0;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      awready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
      wready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
   end

   // Write FSM registers; reset drops held payloads and any pending response
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_state_q <= WR_IDLE;
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   // Read FSM next state: capture data at the AR handshake, hold until R handshake
   always_comb begin
      rd_state_d = rd_state_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (arvalid && arready_q) begin
               rdata_d    = rf_rd_data;
               rresp_d    = rf_rd_in_range ? RESP_OKAY : RESP_SLVERR;
               rvalid_d   = 1'b1;
               rd_state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (rready) begin
               rvalid_d   = 1'b0;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
      arready_d = (rd_state_d == RD_IDLE);
   end

   // Read FSM registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_slave_regfile
//  Brief    : Self-checking bench for axi_lite_slave_regfile against an
//             array-based register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_regfile;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;

   logic                       aclk = 1'b0;
   logic                       areset;
   logic [ADDR_W-1:0]          awaddr;
   logic                       awvalid;
   logic                       awready;
   logic [DATA_W-1:0]          wdata;
   logic [DATA_W/8-1:0]        wstrb;
   logic                       wvalid;
   logic                       wready;
   logic [1:0]                 bresp;
   logic                       bvalid;
   logic                       bready;
   logic [ADDR_W-1:0]          araddr;
   logic                       arvalid;
   logic                       arready;
   logic [DATA_W-1:0]          rdata;
   logic [1:0]                 rresp;
   logic                       rvalid;
   logic                       rready;
   logic [NUM_REGS*DATA_W-1:0] regs_out;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [NUM_REGS];

   axi_lite_slave_regfile #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) dut (
      .aclk     (aclk),
      .areset   (areset),
      .awaddr   (awaddr),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wvalid   (wvalid),
      .wready   (wready),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .araddr   (araddr),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rvalid   (rvalid),
      .rready   (rready),
      .regs_out (regs_out)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (time %0t, need < 2000000)", $time);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic void model_write(int idx, logic [31:0] d, logic [3:0] s);
      if (idx < NUM_REGS)
         for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
   endfunction

   function automatic logic [1:0] exp_resp(int idx);
      return (idx < NUM_REGS) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] exp_read(int idx);
      return (idx < NUM_REGS) ? model[idx] : 32'h0;
   endfunction

   // ---------------- bus drivers (called at a negedge, return at a negedge) ----------------
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit to);
      bit aw_done, w_done, hs_aw, hs_w;
      int n;
      to = 1'b0; resp = 2'b11;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 50) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         @(negedge aclk);
         if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (hs_w)  begin wvalid = 1'b0;  w_done = 1'b1;  end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      if (bvalid !== 1'b1) to = 1'b1;
      else begin resp = bresp; @(negedge aclk); end
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit to);
      bit hs;
      int n;
      to = 1'b0; resp = 2'b11; data = 32'hx;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 50) begin
         hs = arvalid && arready;
         @(negedge aclk);
         n++;
      end
      arvalid = 1'b0;
      n = 0;
      while (rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      if (rvalid !== 1'b1) to = 1'b1;
      else begin data = rdata; resp = rresp; @(negedge aclk); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      areset = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
      repeat (3) @(negedge aclk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got aw/w/ar/b/r=%b need 00000", {awready, wready, arready, bvalid, rvalid});
      end
      checks++;
      if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h need 0/0/0", bresp, rresp, rdata);
      end
      checks++;
      if (regs_out !== '0) begin
         errors++;
         $display("FAIL reset_regs: got %h need 0", regs_out);
      end
      areset = 1'b0;
      @(negedge aclk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_ready_rise: got aw/w/ar=%b need 111", {awready, wready, arready});
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] d; logic [1:0] r; bit to;
      awaddr = 32'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge aclk);                      // edge N: both handshakes
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
         errors++;
         $display("FAIL same_n: got bvalid=%b awready=%b wready=%b need 0/0/0", bvalid, awready, wready);
      end
      @(negedge aclk);                      // edge N+1: commit
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || regs_out[1*32 +: 32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL same_n1: got bvalid=%b bresp=%b reg1=%h need 1/00/deadbeef", bvalid, bresp, regs_out[32 +: 32]);
      end
      @(negedge aclk);                      // edge N+2: B handshake done
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
         errors++;
         $display("FAIL same_n2: got bvalid=%b awready=%b wready=%b need 0/1/1", bvalid, awready, wready);
      end
      model_write(1, 32'hDEADBEEF, 4'hF);
      do_read(32'h04, d, r, to);
      checks++;
      if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin
         errors++;
         $display("FAIL same_read: got timeout=%0d rdata=%h rresp=%b need 0/deadbeef/00", to, d, r);
      end
   endtask

   task automatic test_w_first();
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
      @(negedge aclk);                      // W handshake
      wvalid = 1'b0;
      checks++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL wfirst_w: got wready=%b awready=%b bvalid=%b need 0/1/0", wready, awready, bvalid);
      end
      repeat (2) @(negedge aclk);
      checks++;
      if (bvalid !== 1'b0 || wready !== 1'b0) begin
         errors++;
         $display("FAIL wfirst_wait: got bvalid=%b wready=%b need 0/0", bvalid, wready);
      end
      awaddr = 32'h08; awvalid = 1'b1;
      @(negedge aclk);                      // AW handshake, 3 cycles after W
      awvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         errors++;
         $display("FAIL wfirst_m: got bvalid=%b need 0", bvalid);
      end
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || regs_out[2*32 +: 32] !== 32'h12345678) begin
         errors++;
         $display("FAIL wfirst_m1: got bvalid=%b bresp=%b reg2=%h need 1/00/12345678", bvalid, bresp, regs_out[64 +: 32]);
      end
      @(negedge aclk);
      model_write(2, 32'h12345678, 4'hF);
   endtask

   task automatic test_partial_strobe();
      logic [31:0] d; logic [1:0] r; bit to;
      do_write(32'h0C, 32'hAABBCCDD, 4'hF, r, to);
      model_write(3, 32'hAABBCCDD, 4'hF);
      do_write(32'h0C, 32'h11223344, 4'b0101, r, to);
      model_write(3, 32'h11223344, 4'b0101);
      checks++;
      if (to || r !== 2'b00) begin
         errors++;
         $display("FAIL strobe_bresp: got timeout=%0d bresp=%b need 0/00", to, r);
      end
      do_read(32'h0C, d, r, to);
      checks++;
      if (to || d !== 32'hAA22CC44 || d !== model[3]) begin
         errors++;
         $display("FAIL strobe_read: got %h need aa22cc44", d);
      end
      do_write(32'h0C, 32'hFFFFFFFF, 4'h0, r, to);
      checks++;
      if (to || r !== 2'b00 || regs_out[3*32 +: 32] !== 32'hAA22CC44) begin
         errors++;
         $display("FAIL strobe_zero: got bresp=%b reg3=%h need 00/aa22cc44", r, regs_out[96 +: 32]);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; logic [1:0] r; bit to;
      do_write(32'h40, 32'hCAFEF00D, 4'hF, r, to);
      checks++;
      if (to || r !== 2'b10) begin
         errors++;
         $display("FAIL oor_bresp: got timeout=%0d bresp=%b need 0/10", to, r);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         checks++;
         if (regs_out[i*32 +: 32] !== model[i]) begin
            errors++;
            $display("FAIL oor_reg%0d: got %h need %h", i, regs_out[i*32 +: 32], model[i]);
         end
      end
      do_read(32'h40, d, r, to);
      checks++;
      if (to || d !== 32'h0 || r !== 2'b10) begin
         errors++;
         $display("FAIL oor_read: got timeout=%0d rdata=%h rresp=%b need 0/0/10", to, d, r);
      end
   endtask

   task automatic test_read_during_commit();
      logic [31:0] d; logic [1:0] r; bit to; int n;
      do_write(32'h14, 32'h0BAD0BAD, 4'hF, r, to);
      model_write(5, 32'h0BAD0BAD, 4'hF);
      awaddr = 32'h14; wdata = 32'h600D600D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      @(negedge aclk);                      // AW/W handshake
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL rdc_arready: got %b need 1", arready);
      end
      araddr = 32'h14; arvalid = 1'b1;
      @(negedge aclk);                      // commit and AR handshake on the same edge
      arvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || regs_out[5*32 +: 32] !== 32'h600D600D) begin
         errors++;
         $display("FAIL rdc_commit: got bvalid=%b reg5=%h need 1/600d600d", bvalid, regs_out[160 +: 32]);
      end
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0BAD0BAD) begin
         errors++;
         $display("FAIL rdc_old: got rvalid=%b rdata=%h need 1/0bad0bad", rvalid, rdata);
      end
      @(negedge aclk);
      model_write(5, 32'h600D600D, 4'hF);
   endtask

   task automatic test_backpressure();
      logic [1:0] r0; logic [31:0] rd; bit got, hs_ar; int n;
      awaddr = 32'h18; wdata = 32'h5A5AA5A5; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
      r0 = bresp;
      model_write(6, 32'h5A5AA5A5, 4'hF);
      checks++;
      if (bvalid !== 1'b1 || r0 !== 2'b00) begin
         errors++;
         $display("FAIL bp_start: got bvalid=%b bresp=%b need 1/00", bvalid, r0);
      end
      araddr = 32'h04; arvalid = 1'b1; got = 1'b0; rd = 32'h0;
      for (int c = 0; c < 5; c++) begin
         hs_ar = arvalid && arready;
         @(negedge aclk);
         if (hs_ar) arvalid = 1'b0;
         checks++;
         if (bvalid !== 1'b1 || bresp !== r0 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got bvalid=%b bresp=%b awready=%b wready=%b need 1/%b/0/0",
                     c, bvalid, bresp, awready, wready, r0);
         end
         if (rvalid === 1'b1 && !got) begin got = 1'b1; rd = rdata; end
      end
      arvalid = 1'b0;
      checks++;
      if (!got || rd !== model[1]) begin
         errors++;
         $display("FAIL bp_read: got done=%0d rdata=%h need 1/%h", got, rd, model[1]);
      end
      bready = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || regs_out[6*32 +: 32] !== 32'h5A5AA5A5) begin
         errors++;
         $display("FAIL bp_release: got bvalid=%b awready=%b reg6=%h need 0/1/5a5aa5a5",
                  bvalid, awready, regs_out[192 +: 32]);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] r; bit to;
      awaddr = 32'h1C; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
      @(negedge aclk);                      // AW held, W still pending
      awvalid = 1'b0;
      checks++;
      if (awready !== 1'b0 || wready !== 1'b1) begin
         errors++;
         $display("FAIL rmid_held: got awready=%b wready=%b need 0/1", awready, wready);
      end
      wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
      #2 areset = 1'b1;
      #1;
      wvalid = 1'b0;
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 ||
          rresp !== 2'b00 || rdata !== 32'h0 || regs_out !== '0) begin
         errors++;
         $display("FAIL rmid_reset: got aw/w/ar/b/r=%b bresp=%b rresp=%b rdata=%h regs_nonzero=%0d need all 0",
                  {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata, (regs_out != '0));
      end
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      do_write(32'h30, 32'h9ABCDEF0, 4'hF, r, to);
      model_write(12, 32'h9ABCDEF0, 4'hF);
      checks++;
      if (to || r !== 2'b00) begin
         errors++;
         $display("FAIL rmid_write: got timeout=%0d bresp=%b need 0/00", to, r);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         checks++;
         if (regs_out[i*32 +: 32] !== model[i]) begin
            errors++;
            $display("FAIL rmid_reg%0d: got %h need %h", i, regs_out[i*32 +: 32], model[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d, a, got; logic [3:0] s; logic [1:0] r; bit to; int idx;
      for (int t = 0; t < 60; t++) begin
         idx = $urandom_range(0, NUM_REGS + 3);
         a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            do_write(a, d, s, r, to);
            model_write(idx, d, s);
            checks++;
            if (to || r !== exp_resp(idx)) begin
               errors++;
               $display("FAIL rand_wr%0d: addr=%h got timeout=%0d bresp=%b need 0/%b", t, a, to, r, exp_resp(idx));
            end
         end else begin
            do_read(a, got, r, to);
            checks++;
            if (to || got !== exp_read(idx) || r !== exp_resp(idx)) begin
               errors++;
               $display("FAIL rand_rd%0d: addr=%h got rdata=%h rresp=%b need %h/%b",
                        t, a, got, r, exp_read(idx), exp_resp(idx));
            end
         end
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         checks++;
         if (regs_out[i*32 +: 32] !== model[i]) begin
            errors++;
            $display("FAIL rand_reg%0d: got %h need %h", i, regs_out[i*32 +: 32], model[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_same_cycle();
      test_w_first();
      test_partial_strobe();
      test_out_of_range();
      test_read_during_commit();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
